// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS-32 opcodes, fetch state encoding and reset defaults
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // sll $0,$0,0: decodes as R-type with rd=0, so it has no architectural effect
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_pipe_reg.sv
// rtl/ifid_pipe_reg.sv - valid/instr/pc4 stage register with stall-hold and flush
module ifid_pipe_reg #(
    parameter logic [31:0] FLUSH_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        flush,
    input  logic        src_valid,
    input  logic [31:0] src_instr,
    input  logic [31:0] src_pc4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
);

    // flush beats hold; an invalid slot always carries FLUSH_INSTR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= FLUSH_INSTR;
            pc4   <= 32'd0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= FLUSH_INSTR;
        end else if (!hold) begin
            valid <= src_valid;
            instr <= src_valid ? src_instr : FLUSH_INSTR;
            if (src_valid) begin
                pc4 <= src_pc4;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - MIPS-32 IF stage: PC, imem handshake, IF/ID register (opt. IFETCH_PERF_CNT_EN)
module instr_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR_DEFAULT,
    parameter logic [31:0] NOP_INSTR    = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush
`endif
);
    import mips_pkg::*;

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, pc_plus4;
    logic [31:0]  saved_target, saved_next;
    logic [31:0]  skid_instr, skid_pc4;
    logic [31:0]  target, src_instr, src_pc4;
    logic         run, redirect, xfer, skid_load, src_valid;

    assign redirect  = jump | branch_taken;
    assign target    = align_word(jump ? jump_target : branch_target);
    assign pc_plus4  = pc + 32'd4;
    // run keeps the request low until the first edge after reset release
    assign imem_req  = run && (state != HOLD);
    assign imem_addr = pc;
    assign xfer      = imem_req & imem_ready;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        saved_next = saved_target;
        skid_load  = 1'b0;
        src_valid  = 1'b0;
        src_instr  = imem_rdata;
        src_pc4    = pc_plus4;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if (xfer || !run) begin
                        pc_next = target;
                    end else begin
                        saved_next = target;
                        state_next = DISCARD;
                    end
                end else if (xfer) begin
                    pc_next = pc_plus4;
                    if (stall) begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        src_valid = 1'b1;
                    end
                end
            end
            HOLD: begin
                src_instr = skid_instr;
                src_pc4   = skid_pc4;
                if (redirect) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else if (!stall) begin
                    src_valid  = 1'b1;
                    state_next = FETCH;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    saved_next = target;
                end
                if (xfer) begin
                    pc_next    = saved_next;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_VECTOR;
            saved_target <= 32'd0;
            skid_instr   <= NOP_INSTR;
            skid_pc4     <= 32'd0;
            run          <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            saved_target <= saved_next;
            run          <= 1'b1;
            if (skid_load) begin
                skid_instr <= imem_rdata;
                skid_pc4   <= pc_plus4;
            end
        end
    end

    ifid_pipe_reg #(.FLUSH_INSTR(NOP_INSTR)) u_ifid (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (stall),
        .flush     (redirect),
        .src_valid (src_valid),
        .src_instr (src_instr),
        .src_pc4   (src_pc4),
        .valid     (ifid_valid),
        .instr     (ifid_instr),
        .pc4       (ifid_pc4)
    );

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched   <= 32'd0;
            perf_stall_cyc <= 32'd0;
            perf_flush     <= 32'd0;
        end else begin
            if (src_valid && perf_fetched != 32'hFFFF_FFFF) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall && perf_stall_cyc != 32'hFFFF_FFFF) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (redirect && perf_flush != 32'hFFFF_FFFF) begin
                perf_flush <= perf_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - directed self-checking bench for instr_fetch_stage
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump, imem_ready;
    logic [31:0] branch_target, jump_target, imem_rdata;
    logic        imem_req, ifid_valid;
    logic [31:0] imem_addr, ifid_instr, ifid_pc4;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall_cyc, perf_flush;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush     (perf_flush)
`endif
    );

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h8C01_0004;
            32'h4:   return 32'h0022_1820;
            32'h8:   return 32'hAC03_0008;
            32'hC:   return 32'h1000_0002;
            default: return 32'hA000_0000 | a;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        imem_rdata = instr_at(imem_addr);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; branch_taken = 0; jump = 0; imem_ready = 0;
        branch_target = 0; jump_target = 0; imem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", ifid_instr); end
        checks++; if (ifid_pc4 !== 32'h0) begin failures++; $display("FAIL rst_pc4 got=%h exp=0", ifid_pc4); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
`ifdef IFETCH_PERF_CNT_EN
        checks++; if ({perf_fetched, perf_stall_cyc, perf_flush} !== 96'h0) begin failures++; $display("FAIL rst_perf got=%h/%h/%h exp=0", perf_fetched, perf_stall_cyc, perf_flush); end
`endif
        rst_n = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = instr_at(imem_addr);
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rel_req_before_edge got=%b exp=0", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_instr [4] = '{32'h8C01_0004, 32'h0022_1820, 32'hAC03_0008, 32'h1000_0002};
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ifid_valid !== 1'b0) begin failures++; $display("FAIL seq_c1 got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, ifid_valid); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (ifid_valid !== 1'b1 || ifid_instr !== exp_instr[i] || ifid_pc4 !== 32'(4*i+4) || imem_addr !== 32'(4*i+4)) begin
                failures++; $display("FAIL seq_%0d got v=%b i=%h pc4=%h addr=%h exp 1/%h/%h/%h", i, ifid_valid, ifid_instr, ifid_pc4, imem_addr, exp_instr[i], 4*i+4, 4*i+4);
            end
        end
    endtask

    task automatic test_ready_low();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1 || ifid_valid !== 1'b0) begin failures++; $display("FAIL wait_%0d got addr=%h req=%b v=%b exp 8/1/0", i, imem_addr, imem_req, ifid_valid); end
        end
        imem_ready = 1'b1;
        tick();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'hAC03_0008 || ifid_pc4 !== 32'hC || imem_addr !== 32'hC) begin failures++; $display("FAIL wait_capture got v=%b i=%h pc4=%h addr=%h", ifid_valid, ifid_instr, ifid_pc4, imem_addr); end
        tick();
        checks++; if (ifid_instr !== 32'h1000_0002 || ifid_pc4 !== 32'h10 || imem_addr !== 32'h10) begin failures++; $display("FAIL seq_c got i=%h pc4=%h addr=%h exp 10000002/10/10", ifid_instr, ifid_pc4, imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (imem_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0002 || ifid_pc4 !== 32'h10 || imem_addr !== 32'h14) begin
                failures++; $display("FAIL stall_%0d got req=%b v=%b i=%h pc4=%h addr=%h", i, imem_req, ifid_valid, ifid_instr, ifid_pc4, imem_addr);
            end
        end
        stall = 1'b0;
        tick();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_0010 || ifid_pc4 !== 32'h14 || imem_addr !== 32'h14 || imem_req !== 1'b1) begin failures++; $display("FAIL stall_release got v=%b i=%h pc4=%h addr=%h req=%b", ifid_valid, ifid_instr, ifid_pc4, imem_addr, imem_req); end
        tick();
        checks++; if (ifid_instr !== 32'hA000_0014 || ifid_pc4 !== 32'h18 || imem_addr !== 32'h18) begin failures++; $display("FAIL after_stall got i=%h pc4=%h addr=%h", ifid_instr, ifid_pc4, imem_addr); end
    endtask

    task automatic test_branch_discard();
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h42;
        tick();
        branch_taken = 1'b0;
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || imem_addr !== 32'h18 || imem_req !== 1'b1) begin failures++; $display("FAIL br_flush got v=%b i=%h addr=%h req=%b", ifid_valid, ifid_instr, imem_addr, imem_req); end
        tick();
        checks++; if (imem_addr !== 32'h18 || ifid_valid !== 1'b0) begin failures++; $display("FAIL br_discard_hold got addr=%h v=%b exp 18/0", imem_addr, ifid_valid); end
        imem_ready = 1'b1;
        tick();
        checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h40) begin failures++; $display("FAIL br_dropped got v=%b addr=%h exp 0/40", ifid_valid, imem_addr); end
        tick();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_0040 || ifid_pc4 !== 32'h44) begin failures++; $display("FAIL br_target_fetch got v=%b i=%h pc4=%h", ifid_valid, ifid_instr, ifid_pc4); end
    endtask

    task automatic test_jump_priority();
        stall = 1'b1; jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h80;
        tick();
        stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin failures++; $display("FAIL jmp_prio got v=%b i=%h addr=%h req=%b", ifid_valid, ifid_instr, imem_addr, imem_req); end
        tick();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_0100 || ifid_pc4 !== 32'h104 || imem_addr !== 32'h104) begin failures++; $display("FAIL jmp_fetch got v=%b i=%h pc4=%h addr=%h", ifid_valid, ifid_instr, ifid_pc4, imem_addr); end
    endtask

    task automatic test_wrap_and_hold_redirect();
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        tick();
        jump = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL jmp_align got addr=%h exp fffffffc", imem_addr); end
        tick();
        checks++; if (ifid_pc4 !== 32'h0 || imem_addr !== 32'h0 || ifid_instr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL pc_wrap got pc4=%h addr=%h i=%h", ifid_pc4, imem_addr, ifid_instr); end
        stall = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0 || ifid_pc4 !== 32'h0) begin failures++; $display("FAIL hold_enter got req=%b pc4=%h exp 0/0", imem_req, ifid_pc4); end
        branch_taken = 1'b1; branch_target = 32'h200;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin failures++; $display("FAIL hold_redirect got v=%b addr=%h req=%b", ifid_valid, imem_addr, imem_req); end
        tick();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_0200 || ifid_pc4 !== 32'h204) begin failures++; $display("FAIL hold_redirect_fetch got v=%b i=%h pc4=%h", ifid_valid, ifid_instr, ifid_pc4); end
    endtask

    task automatic test_reset_mid_discard();
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
        tick();
        branch_taken = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL midrst got req=%b v=%b addr=%h exp 0/0/0", imem_req, ifid_valid, imem_addr); end
`ifdef IFETCH_PERF_CNT_EN
        checks++; if ({perf_fetched, perf_stall_cyc, perf_flush} !== 96'h0) begin failures++; $display("FAIL midrst_perf got=%h/%h/%h exp=0", perf_fetched, perf_stall_cyc, perf_flush); end
`endif
        imem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ifid_valid !== 1'b0) begin failures++; $display("FAIL midrst_restart got req=%b addr=%h v=%b", imem_req, imem_addr, ifid_valid); end
        tick();
        checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h8C01_0004 || ifid_pc4 !== 32'h4) begin failures++; $display("FAIL midrst_first got v=%b i=%h pc4=%h", ifid_valid, ifid_instr, ifid_pc4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ready_low();
        test_stall();
        test_branch_discard();
        test_jump_priority();
        test_wrap_and_hold_redirect();
        test_reset_mid_discard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
